// File: rtl/im2_int_controller_pkg.sv
// Shared definitions for the IM2 interrupt controller: CPU bus view,
// RETI opcode bytes, source indices and the RETI snoop state type.
package im2_int_controller_pkg;

    localparam logic [7:0] OPC_ED    = 8'hED;
    localparam logic [7:0] OPC_RETI2 = 8'h4D;

    localparam int INT_SRC_FRAME = 0;
    localparam int INT_SRC_LINE  = 1;
    localparam int INT_SRC_UART  = 2;
    localparam int INT_SRC_EXT   = 3;

    typedef struct packed {
        logic       m1;
        logic       mreq;
        logic       iorq;
        logic       rd;
        logic [7:0] d;
    } cpu_bus_t;

    typedef enum logic {
        RETI_IDLE,
        RETI_GOT_ED
    } reti_state_t;

endpackage

// File: rtl/im2_int_controller_reti_detect.sv
// Snoops opcode fetches for the ED 4D (RETI) pair and emits a one-clk28 strobe.
//
// state        | meaning
// RETI_IDLE    | no ED prefix pending
// RETI_GOT_ED  | last fetched opcode was ED
module im2_int_controller_reti_detect
    import im2_int_controller_pkg::*;
(
    input  logic     clk28,
    input  logic     rst,
    input  cpu_bus_t bus,
    output logic     reti
);

    reti_state_t state;
    logic        fetch;
    logic        fetch_q;

    // An IM2 acknowledge carries iorq instead of mreq, so it never counts as a fetch.
    assign fetch = bus.m1 & bus.mreq & bus.rd & ~bus.iorq;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state   <= RETI_IDLE;
            fetch_q <= 1'b0;
            reti    <= 1'b0;
        end else begin
            fetch_q <= fetch;
            reti    <= 1'b0;
            if (fetch_q && !fetch) begin
                case (state)
                    RETI_IDLE: begin
                        if (bus.d == OPC_ED)
                            state <= RETI_GOT_ED;
                    end
                    RETI_GOT_ED: begin
                        if (bus.d == OPC_RETI2) begin
                            state <= RETI_IDLE;
                            reti  <= 1'b1;
                        end else if (bus.d != OPC_ED) begin
                            state <= RETI_IDLE;
                        end
                    end
                    default: state <= RETI_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/im2_int_controller.sv
// Z80 IM2 interrupt responder: fixed-priority pending/in-service tracking,
// INT generation, vector return on M1+IORQ and RETI-driven retirement.
module im2_int_controller
    import im2_int_controller_pkg::*;
#(
    parameter int NSRC    = 4,
    parameter int INT_LEN = 32
) (
    input  logic            clk28,
    input  logic            rst,
    input  logic            clkcpu_ck,
    input  cpu_bus_t        bus,
    input  logic [NSRC-1:0] irq,
    input  logic [NSRC-1:0] src_en,
    input  logic [NSRC-1:0] src_pulse,
    input  logic [4:0]      vec_base,
    output logic            n_int,
    output logic [7:0]      d_out,
    output logic            d_out_oe,
    output logic [NSRC-1:0] in_service
);

    localparam int         IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [5:0] TC = 6'(INT_LEN - 1);

    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] req_set;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] tmo_clr;
    logic [NSRC-1:0] reti_clr;
    logic [5:0]      tmo_cnt [NSRC];
    logic [IW-1:0]   win;
    logic            any_pend;
    logic            eligible;
    logic            ack;
    logic            ack_q;
    logic            ack_rise;
    logic            reti;

    im2_int_controller_reti_detect u_reti_detect (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (bus),
        .reti  (reti)
    );

    assign ack      = bus.m1 & bus.iorq;
    assign ack_rise = ack & ~ack_q;
    assign req_set  = irq & src_en;
    assign reti_clr = reti ? (in_service & (~in_service + NSRC'(1))) : '0;

    always_comb begin
        win      = '0;
        any_pend = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win      = IW'(i);
                any_pend = 1'b1;
            end
        end
    end

    // Only a strictly higher-priority source may nest over one in service.
    always_comb begin
        eligible = any_pend;
        for (int i = 0; i < NSRC; i++) begin
            if (in_service[i] && (i <= int'(win)))
                eligible = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = ack_rise & eligible & (win == IW'(i));
            tmo_clr[i] = pending[i] & src_pulse[i] & clkcpu_ck & (tmo_cnt[i] == TC);
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
            n_int      <= 1'b1;
            d_out      <= 8'hFF;
            d_out_oe   <= 1'b0;
            ack_q      <= 1'b0;
            for (int i = 0; i < NSRC; i++)
                tmo_cnt[i] <= '0;
        end else begin
            ack_q      <= ack;
            pending    <= req_set | (pending & ~(ack_clr | tmo_clr));
            in_service <= (in_service & ~reti_clr) | ack_clr;
            if (clkcpu_ck)
                n_int <= ~eligible;
            if (ack_rise) begin
                d_out_oe <= 1'b1;
                d_out    <= eligible ? {vec_base, 2'(win), 1'b0} : 8'hFF;
            end else if (!ack) begin
                d_out_oe <= 1'b0;
            end
            // A retired or re-armed request starts a fresh INT window.
            for (int i = 0; i < NSRC; i++) begin
                if (!pending[i] || !src_pulse[i] || ack_clr[i] || tmo_clr[i])
                    tmo_cnt[i] <= '0;
                else if (clkcpu_ck)
                    tmo_cnt[i] <= tmo_cnt[i] + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_im2_int_controller.sv
// Self-checking bench for im2_int_controller: directed scenarios plus a
// randomized run against a behavioural model of the interrupt rules.
module tb_im2_int_controller;
    import im2_int_controller_pkg::*;

    localparam int INT_LEN = 32;

    logic       clk28 = 1'b0;
    logic       rst;
    logic       clkcpu_ck = 1'b0;
    cpu_bus_t   bus;
    logic [3:0] irq, src_en, src_pulse;
    logic [4:0] vec_base;
    logic       n_int;
    logic [7:0] d_out;
    logic       d_out_oe;
    logic [3:0] in_service;

    int checks = 0;
    int errors = 0;
    bit last_ck;

    // behavioural model state
    bit         m_pend [4];
    bit         m_isv  [4];
    int         m_cnt  [4];
    bit         m_nint, m_oe, m_ack_prev, m_fetch_prev, m_got_ed, m_reti_q;
    logic [7:0] m_dout;

    im2_int_controller #(.NSRC(4), .INT_LEN(INT_LEN)) dut (
        .clk28      (clk28),
        .rst        (rst),
        .clkcpu_ck  (clkcpu_ck),
        .bus        (bus),
        .irq        (irq),
        .src_en     (src_en),
        .src_pulse  (src_pulse),
        .vec_base   (vec_base),
        .n_int      (n_int),
        .d_out      (d_out),
        .d_out_oe   (d_out_oe),
        .in_service (in_service)
    );

    initial forever #5 clk28 = ~clk28;

    initial begin : ck_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk28);
            #1;
            div = (div + 1) % 4;
            clkcpu_ck = (div == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int m_winner();
        for (int i = 0; i < 4; i++) if (m_pend[i]) return i;
        return -1;
    endfunction

    function automatic bit m_eligible(int w);
        if (w < 0) return 1'b0;
        for (int j = 0; j <= w; j++) if (m_isv[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_isv_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_isv[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_isv[i] = 0; m_cnt[i] = 0; end
        m_nint = 1; m_oe = 0; m_dout = 8'hFF;
        m_ack_prev = 0; m_fetch_prev = 0; m_got_ed = 0; m_reti_q = 0;
    endtask

    task automatic model_step();
        int w, k;
        bit elig, ack, fetch;
        bit np [4];
        bit ni [4];
        bit clr [4];
        ack   = bus.m1 && bus.iorq;
        fetch = bus.m1 && bus.mreq && bus.rd;
        w     = m_winner();
        elig  = m_eligible(w);
        np = m_pend; ni = m_isv;
        for (int i = 0; i < 4; i++) clr[i] = 0;
        if (clkcpu_ck) m_nint = !elig;
        if (ack && !m_ack_prev) begin
            m_oe = 1;
            if (elig) begin
                m_dout = {vec_base, w[1:0], 1'b0};
                np[w] = 0; ni[w] = 1; clr[w] = 1;
            end else begin
                m_dout = 8'hFF;
            end
        end else if (!ack) begin
            m_oe = 0;
        end
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && src_pulse[i] && clkcpu_ck && (m_cnt[i] + 1 == INT_LEN)) begin
                np[i] = 0; clr[i] = 1;
            end
        if (m_reti_q) begin
            k = -1;
            for (int i = 3; i >= 0; i--) if (m_isv[i]) k = i;
            if (k >= 0) ni[k] = 0;
        end
        m_reti_q = 0;
        if (m_fetch_prev && !fetch) begin
            m_reti_q = m_got_ed && (bus.d == 8'h4D);
            m_got_ed = (bus.d == 8'hED);
        end
        for (int i = 0; i < 4; i++) if (irq[i] && src_en[i]) np[i] = 1;
        for (int i = 0; i < 4; i++)
            if (!m_pend[i] || clr[i] || !src_pulse[i]) m_cnt[i] = 0;
            else if (clkcpu_ck) m_cnt[i] = m_cnt[i] + 1;
        m_pend = np; m_isv = ni;
        m_ack_prev = ack; m_fetch_prev = fetch;
    endtask

    task automatic tick();
        @(posedge clk28);
        last_ck = clkcpu_ck;
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic wait_ck();
        int n;
        n = 0;
        do begin tick(); n++; end while (!last_ck && n < 16);
    endtask

    task automatic pulse_irq(input logic [3:0] m);
        irq = m; tick(); irq = '0;
    endtask

    task automatic ack_cycle(output logic [7:0] dv, output logic oe);
        bus.m1 = 1; bus.iorq = 1;
        tick(); dv = d_out; oe = d_out_oe;
        tick(); tick();
        bus.m1 = 0; bus.iorq = 0;
        tick();
    endtask

    task automatic fetch(input logic [7:0] opc);
        bus.m1 = 1; bus.mreq = 1; bus.rd = 1; bus.d = opc;
        tick(); tick();
        bus.m1 = 0; bus.mreq = 0; bus.rd = 0;
        tick(); tick();
        bus.d = '0;
        tick();
    endtask

    task automatic data_read(input logic [7:0] v);
        bus.mreq = 1; bus.rd = 1; bus.d = v;
        tick(); tick();
        bus.mreq = 0; bus.rd = 0;
        tick(); tick();
        bus.d = '0;
    endtask

    task automatic serve(input logic [3:0] m);
        logic [7:0] dv;
        logic oe;
        pulse_irq(m); wait_ck(); ack_cycle(dv, oe);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL reset_nint: got %b want 1", n_int); end
        checks++; if (d_out !== 8'hFF) begin errors++; $display("FAIL reset_dout: got %h want ff", d_out); end
        checks++; if (d_out_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", d_out_oe); end
        checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL reset_isv: got %b want 0000", in_service); end
        @(negedge clk28); rst = 0;
        repeat (8) tick();
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL reset_idle_nint: got %b want 1", n_int); end
    endtask

    task automatic test_basic();
        logic [7:0] dv;
        logic oe;
        pulse_irq(4'b0100);
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", n_int); end
        wait_ck();
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL basic_nint_low: got %b want 0", n_int); end
        ack_cycle(dv, oe);
        checks++; if (dv !== 8'hF4) begin errors++; $display("FAIL basic_vector: got %h want f4", dv); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b want 1", oe); end
        checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL basic_isv: got %b want 0100", in_service); end
        checks++; if (d_out_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_drop: got %b want 0", d_out_oe); end
        checks++; if (d_out !== 8'hF4) begin errors++; $display("FAIL basic_dout_hold: got %h want f4", d_out); end
        wait_ck();
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL basic_nint_high: got %b want 1", n_int); end
        fetch(8'hED); fetch(8'h4D);
        checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL basic_reti: got %b want 0000", in_service); end
    endtask

    task automatic test_priority();
        logic [7:0] dv;
        logic oe;
        pulse_irq(4'b1000); wait_ck();
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL prio_src3_int: got %b want 0", n_int); end
        ack_cycle(dv, oe);
        checks++; if (dv !== 8'hF6) begin errors++; $display("FAIL prio_src3_vec: got %h want f6", dv); end
        checks++; if (in_service !== 4'b1000) begin errors++; $display("FAIL prio_isv3: got %b want 1000", in_service); end
        pulse_irq(4'b0010); wait_ck();
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL prio_nest_int: got %b want 0", n_int); end
        ack_cycle(dv, oe);
        checks++; if (dv !== 8'hF2) begin errors++; $display("FAIL prio_nest_vec: got %h want f2", dv); end
        checks++; if (in_service !== 4'b1010) begin errors++; $display("FAIL prio_isv31: got %b want 1010", in_service); end
        pulse_irq(4'b0100); wait_ck(); wait_ck();
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL prio_blocked: got %b want 1", n_int); end
        fetch(8'hED); fetch(8'h4D);
        checks++; if (in_service !== 4'b1000) begin errors++; $display("FAIL prio_reti1: got %b want 1000", in_service); end
        wait_ck();
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL prio_unblocked: got %b want 0", n_int); end
        ack_cycle(dv, oe);
        checks++; if (dv !== 8'hF4) begin errors++; $display("FAIL prio_src2_vec: got %h want f4", dv); end
        fetch(8'hED); fetch(8'h4D); fetch(8'hED); fetch(8'h4D);
        checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL prio_cleanup: got %b want 0000", in_service); end
    endtask

    task automatic test_reti();
        serve(4'b0100); serve(4'b0010);
        checks++; if (in_service !== 4'b0110) begin errors++; $display("FAIL reti_setup: got %b want 0110", in_service); end
        fetch(8'hED); fetch(8'h4D);
        checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL reti_ed4d: got %b want 0100", in_service); end
        serve(4'b0010);
        fetch(8'hED); fetch(8'hED); fetch(8'h4D);
        checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL reti_eded4d: got %b want 0100", in_service); end
        fetch(8'hED); fetch(8'h00); fetch(8'h4D);
        checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL reti_ed004d: got %b want 0100", in_service); end
        data_read(8'hED); fetch(8'h4D);
        checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL reti_dataread: got %b want 0100", in_service); end
        fetch(8'hED); fetch(8'h4D); fetch(8'hED); fetch(8'h4D);
        checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL reti_empty: got %b want 0000", in_service); end
        wait_ck();
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL reti_empty_nint: got %b want 1", n_int); end
    endtask

    task automatic test_timeout();
        logic [7:0] dv;
        logic oe;
        int lows;
        bit seen_low, done;
        lows = 0; seen_low = 0; done = 0;
        src_pulse = 4'b0001;
        pulse_irq(4'b0001);
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (last_ck) begin
                if (n_int === 1'b0) begin lows++; seen_low = 1; end
                else if (seen_low) done = 1;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL timeout_release: got n_int %b want 1 within bound", n_int); end
        checks++; if (lows != INT_LEN) begin errors++; $display("FAIL timeout_len: got %0d want %0d cpu cycles low", lows, INT_LEN); end
        src_pulse = 4'b0000;
        pulse_irq(4'b0001);
        repeat (40) wait_ck();
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL held_stays: got %b want 0", n_int); end
        ack_cycle(dv, oe);
        checks++; if (dv !== 8'hF0) begin errors++; $display("FAIL held_vec: got %h want f0", dv); end
        fetch(8'hED); fetch(8'h4D);
    endtask

    task automatic test_simultaneous();
        logic [7:0] dv;
        logic oe;
        pulse_irq(4'b0010); wait_ck();
        bus.m1 = 1; bus.iorq = 1; irq = 4'b0010;
        tick();
        irq = '0; dv = d_out;
        tick(); tick();
        bus.m1 = 0; bus.iorq = 0;
        tick();
        checks++; if (dv !== 8'hF2) begin errors++; $display("FAIL simul_vec: got %h want f2", dv); end
        checks++; if (in_service !== 4'b0010) begin errors++; $display("FAIL simul_isv: got %b want 0010", in_service); end
        wait_ck(); wait_ck();
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL simul_blocked: got %b want 1", n_int); end
        fetch(8'hED); fetch(8'h4D); wait_ck();
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL simul_repend: got %b want 0", n_int); end
        ack_cycle(dv, oe);
        checks++; if (dv !== 8'hF2) begin errors++; $display("FAIL simul_revec: got %h want f2", dv); end
        fetch(8'hED); fetch(8'h4D);
        ack_cycle(dv, oe);
        checks++; if (dv !== 8'hFF || oe !== 1'b1) begin errors++; $display("FAIL spurious_vec: got %h/%b want ff/1", dv, oe); end
        checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL spurious_isv: got %b want 0000", in_service); end
        wait_ck();
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL spurious_nint: got %b want 1", n_int); end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] dv;
        logic oe;
        pulse_irq(4'b0100); wait_ck();
        bus.m1 = 1; bus.iorq = 1;
        tick();
        checks++; if (d_out_oe !== 1'b1) begin errors++; $display("FAIL rstack_oe_before: got %b want 1", d_out_oe); end
        #2; rst = 1; model_reset(); #1;
        checks++; if (d_out_oe !== 1'b0) begin errors++; $display("FAIL rstack_oe: got %b want 0", d_out_oe); end
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL rstack_nint: got %b want 1", n_int); end
        checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL rstack_isv: got %b want 0000", in_service); end
        bus = '0;
        @(negedge clk28); rst = 0;
        repeat (10) wait_ck();
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL rstack_no_int: got %b want 1", n_int); end
        pulse_irq(4'b0001); wait_ck();
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL rstack_new_irq: got %b want 0", n_int); end
        ack_cycle(dv, oe);
        fetch(8'hED); fetch(8'h4D);
    endtask

    task automatic test_random();
        int hold;
        logic [7:0] opc;
        rst = 1; model_reset(); bus = '0; irq = '0;
        #12; @(negedge clk28); rst = 0;
        for (int ph = 0; ph < 3; ph++) begin
            src_en    = 4'($urandom_range(0, 15)) | 4'b0001;
            src_pulse = 4'($urandom_range(0, 15));
            vec_base  = 5'($urandom_range(0, 31));
            hold = 0;
            for (int c = 0; c < 1000; c++) begin
                if (hold == 0) begin
                    bus = '0;
                    case ($urandom_range(0, 3))
                        0: opc = 8'hED;
                        1: opc = 8'h4D;
                        2: opc = 8'h00;
                        default: opc = 8'($urandom_range(0, 255));
                    endcase
                    case ($urandom_range(0, 6))
                        2: begin bus.m1 = 1; bus.iorq = 1; end
                        3, 4: begin bus.m1 = 1; bus.mreq = 1; bus.rd = 1; bus.d = opc; end
                        5: begin bus.mreq = 1; bus.rd = 1; bus.d = opc; end
                        6: begin bus.mreq = 1; bus.d = opc; end
                        default: bus.d = opc;
                    endcase
                    hold = $urandom_range(1, 4);
                end
                hold--;
                for (int i = 0; i < 4; i++) irq[i] = ($urandom_range(0, 11) == 0);
                tick();
                checks++;
                if ({n_int, d_out, d_out_oe, in_service} !== {m_nint, m_dout, m_oe, m_isv_vec()}) begin
                    errors++;
                    $display("FAIL random_c%0d: got n_int=%b d_out=%h oe=%b isv=%b want n_int=%b d_out=%h oe=%b isv=%b",
                             c, n_int, d_out, d_out_oe, in_service, m_nint, m_dout, m_oe, m_isv_vec());
                end
            end
        end
        irq = '0; bus = '0;
    endtask

    initial begin
        rst = 1; bus = '0; irq = '0;
        src_en = 4'hF; src_pulse = 4'h0; vec_base = 5'b11110;
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_reti();
        test_timeout();
        test_simultaneous();
        test_reset_mid_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/im2_int_controller.md
Name: im2_int_controller

Overview:
- Interrupt responder on the CPU side of the INT line driven towards the Z80.
- Collects single-cycle interrupt requests from NSRC sources (frame, line, UART, …) and arbitrates them by fixed priority.
- Drives a combined active-low INT towards the CPU.
- Answers the IM2 acknowledge cycle (M1+IORQ) with a per-source vector byte.
- Snoops opcode fetches for RETI (ED 4D) to retire the in-service source.
- Sits beside cpucontrol; its n_int is ANDed with the frame INT at top level.

Parameters:
- NSRC, 4, number of request sources; index 0 is highest priority.
- INT_LEN, 32, CPU T-states a pulse-mode request stays pending without acknowledge.

Ports:
- clk28  in  1  system clock, 28 MHz.
- rst  in  1  asynchronous, active-high reset.
- clkcpu_ck  in  1  one-clk28 strobe per CPU rising edge, from cpucontrol.
- bus  in  cpu_bus  CPU bus interface; uses m1, mreq, iorq, rd and d[7:0].
- irq  in  NSRC  request strobes, one clk28 wide each.
- src_en  in  NSRC  per-source enable; a disabled source never becomes pending.
- src_pulse  in  NSRC  1 = pulse mode (drops after INT_LEN); 0 = held until acknowledged.
- vec_base  in  5  bits [7:3] of the vector byte.
- n_int  out  1  active-low INT to the CPU.
- d_out  out  8  vector byte.
- d_out_oe  out  1  d_out valid; the top-level data mux selects it.
- in_service  out  NSRC  debug/status.

Behaviour:
- All state registers clk28, asynchronous reset on rst high.
  - Reset values: pending=0, in_service=0, n_int=1, d_out=8'hFF, d_out_oe=0, RETI FSM=IDLE, timeout counters=0.
- Pending set: irq[i] & src_en[i] sets pending[i] on the next clk28 edge.
  - Multiple strobes while pending coalesce into one request.
  - Set has priority over every clear in the same cycle.
- Arbitration: win = lowest-index i with pending[i].
  - Request is eligible if no in_service[j] with j<=win (nesting allowed for higher priority only).
- n_int: registered on clk28, updated only when clkcpu_ck=1. Value is 0 while an eligible request exists, else 1.
  - Latency from irq to n_int low: 1 clk28 plus wait for the next clkcpu_ck.
- Acknowledge detect: ack = bus.m1 & bus.iorq.
  - ack_rise is the first clk28 with ack high after it was low.
  - On ack_rise with an eligible winner w:
    - pending[w] cleared, in_service[w] set.
    - d_out = {vec_base, w[1:0], 1'b0}, d_out_oe=1.
    - n_int recomputed on the following clkcpu_ck.
  - On ack_rise with no eligible request (spurious): d_out=8'hFF, d_out_oe=1, no state change.
  - d_out_oe drops on the first clk28 with ack low; d_out holds its value.
- Pulse-mode timeout: per-source 6-bit counter.
  - Cleared when pending rises; incremented on clkcpu_ck while pending.
  - Reaching INT_LEN with src_pulse[i]=1 clears pending[i] (Spectrum-compatible 32 T INT).
  - Counter is inactive for held-mode sources.
- RETI snoop: opcode byte sampled from bus.d on the clk28 where bus.m1 & bus.mreq & bus.rd falls. FSM:
  - IDLE: ED -> GOT_ED; anything else stays IDLE.
  - GOT_ED: 4D -> IDLE and clear the lowest-index set bit of in_service; ED -> GOT_ED; other -> IDLE.
  - RETI with in_service=0 has no effect.
  - Non-M1 reads/writes never move the FSM. ack cycles are M1 without mreq and are ignored.
- Reset mid-acknowledge: d_out_oe drops immediately (asynchronous) and n_int=1.

Decomposition:
- Shared common package:
  - RETI opcode constants OPC_ED=8'hED and OPC_RETI2=8'h4D.
  - Source index constants INT_SRC_FRAME=0, INT_SRC_LINE=1, INT_SRC_UART=2, INT_SRC_EXT=3.
- Sub-module reti_detect:
  - Inputs: clk28, rst, bus.
  - Output: one-clk28 reti strobe.
  - Contains the opcode sampler and the two-state FSM.
- Arbitration, pending/in-service and timeout counters stay in the top module.

Test Plan:
- Basic IM2: vec_base=5'b11110, src_en=4'hF, irq[2] pulse.
  - n_int low at the next clkcpu_ck.
  - ack returns d_out=8'hF4 with d_out_oe=1.
  - in_service=4'b0100; n_int high after the next clkcpu_ck.
- Priority and nesting:
  - irq[3] acked (in_service=1000), then irq[1] -> n_int low again and vector 8'hF2.
  - Then irq[2] while 1 is in service -> n_int stays high until RETI, then goes low.
- RETI snoop:
  - Fetch sequence ED,4D clears only the lowest in-service bit.
  - ED,ED,4D also clears it.
  - ED,00,4D clears nothing.
  - A data read of ED then an M1 fetch of 4D clears nothing.
- Pulse timeout: src_pulse[0]=1, irq[0], no ack.
  - pending drops after exactly 32 clkcpu_ck; n_int returns high.
  - With src_pulse[0]=0 it stays low indefinitely.
- Simultaneous events and spurious ack:
  - irq[1] on the same clk28 as ack_rise serving source 1 -> pending[1] remains 1 afterwards.
  - ack with nothing pending -> d_out=8'hFF, state unchanged.
- Reset: assert rst during an ack with d_out_oe=1.
  - d_out_oe=0, n_int=1, pending=in_service=0 in the same cycle.
  - After release, no INT occurs until a new irq.
